instr_ram_arbiter: RTL and testbench
====================================

# instr_ram_arbiter

Two-port front end for the single-port instruction RAM wrapper. Shares one RAM port between the core instruction-fetch interface (read-only) and the debug/AXI loader interface (read/write). Grants the RAM cycle by cycle and returns read data with a registered valid. Fetch has fixed priority, with an optional starvation guard for the loader. Sits between the core/debug bus and the instruction RAM wrapper in the core region.

## Interface
- ADDR_WIDTH, 15: byte address width; matches the RAM wrapper.
- DATA_WIDTH, 32: data width; byte enables are DATA_WIDTH/8.
- MAX_WAIT, 8: loader starvation limit in cycles; minimum 1. Used only with the starvation guard.

- clk  in  1  single clock, rising edge.
- rstn_i  in  1  asynchronous active-low reset.
- fetch_req_i  in  1  fetch request.
- fetch_addr_i  in  ADDR_WIDTH  fetch byte address.
- fetch_gnt_o  out  1  fetch request accepted this cycle.
- fetch_rvalid_o  out  1  fetch read data valid.
- fetch_rdata_o  out  DATA_WIDTH  fetch read data.
- dbg_req_i  in  1  loader request.
- dbg_we_i  in  1  loader write (1) / read (0).
- dbg_be_i  in  DATA_WIDTH/8  loader byte enables.
- dbg_addr_i  in  ADDR_WIDTH  loader byte address.
- dbg_wdata_i  in  DATA_WIDTH  loader write data.
- dbg_gnt_o  out  1  loader request accepted.
- dbg_rvalid_o  out  1  loader response (read data or write ack).
- dbg_rdata_o  out  DATA_WIDTH  loader read data.
- ram_en_o, ram_we_o  out  1  RAM enable / write enable.
- ram_addr_o  out  ADDR_WIDTH  RAM address.
- ram_wdata_o  out  DATA_WIDTH  RAM write data.
- ram_be_o  out  DATA_WIDTH/8  RAM byte enables.
- ram_rdata_i  in  DATA_WIDTH  RAM read data, valid one cycle after ram_en_o.
- dbg_starved_o  out  1  guard currently forcing loader priority; 0 when guard compiled out.

## Operation
- Req/gnt handshake: a requester holds req and all request fields stable until it sees gnt in the same cycle.
- Grant is combinational. At most one of fetch_gnt_o and dbg_gnt_o is high per cycle. A gnt is never asserted without the matching req.
- Default arbitration:
  - fetch_req_i high: fetch wins.
  - Otherwise dbg_req_i high: loader wins.
  - Neither: no grant.
- RAM port is driven combinationally from the winner:
  - ram_en_o = any grant.
  - Fetch winner: ram_we_o=0, ram_be_o all ones.
  - Loader winner: ram_we_o=dbg_we_i, ram_be_o=dbg_be_i, ram_wdata_o=dbg_wdata_i.
  - No grant: ram_addr_o, ram_wdata_o and ram_be_o hold the loader's values; ram_en_o=0, ram_we_o=0.
- Response owner register, states IDLE / FETCH / DBG:
  - Loaded every cycle with the current winner, or IDLE if no grant.
  - fetch_rvalid_o = (owner==FETCH). dbg_rvalid_o = (owner==DBG).
- Read data: fetch_rdata_o and dbg_rdata_o both carry ram_rdata_i unqualified. Consumers qualify with rvalid.
- Writes: dbg_rvalid_o pulses one cycle after grant as the write ack. dbg_rdata_o content is don't-care for a write.
- Back-to-back grants every cycle are legal. The response for grant N coincides with grant N+1.

## Timing
- Reset values: owner=IDLE, fetch_rvalid_o=0, dbg_rvalid_o=0, starvation counter=0, dbg_starved_o=0.
- Combinational outputs (gnt, ram_*) follow the inputs even during reset. Reset does not gate them.
- Latency: gnt in cycle T gives rvalid in cycle T+1. Exactly one rvalid per grant; no buffering.
- Reset asserted mid-operation: pending rvalid is dropped; owner returns to IDLE asynchronously.
- Simultaneous requests: only the loser sees gnt=0. Its request stays pending.

## Configuration
- INSTR_ARB_STARVE_GUARD_EN defined:
  - Counter width $clog2(MAX_WAIT+1).
  - Counter increments each cycle dbg_req_i=1 && dbg_gnt_o=0. It saturates at MAX_WAIT and clears on dbg_gnt_o or when dbg_req_i=0.
  - When counter==MAX_WAIT: dbg_starved_o=1 and the loader wins over fetch. This lasts exactly one grant; the counter then clears.
- Not defined: pure fixed fetch priority. No counter; dbg_starved_o tied 0.

## Test plan
- Fetch alone, addr 0x0010 then 0x0014 back to back: fetch_gnt_o=1 both cycles. fetch_rvalid_o=1 at T+1 and T+2 carrying the RAM word for each address. ram_we_o=0 throughout.
- Loader write 0x0040, be=4'b0011, data 0xDEADBEEF, then read 0x0040: dbg_rvalid_o pulses after each grant. Read returns 0xXXXXBEEF, with upper bytes holding the prior contents.
- Both requesting in one cycle, guard off: fetch granted, dbg_gnt_o=0. The loader is granted in the first cycle fetch_req_i=0, and dbg_rvalid_o follows one cycle later.
- Guard on, MAX_WAIT=8, fetch requesting continuously, loader requesting from T0: dbg_gnt_o=1 and dbg_starved_o=1 at T8. Fetch gnt=0 at T8 and resumes at T9; the counter is back at 0.
- Reset asserted in the cycle after a loader read grant: dbg_rvalid_o=0 immediately and stays 0 after release. Owner is IDLE, and the next grant behaves normally.

Source files
------------

// File: rtl/instr_ram_arbiter.sv
// instr_ram_arbiter
// Shares the single port of the instruction RAM wrapper between the core
// instruction-fetch interface (read-only) and the debug/AXI loader interface
// (read/write). Grants are combinational and made cycle by cycle. Read data
// and write acks come back one cycle later, qualified by a registered valid.
//
// Arbitration: fetch has fixed priority over the loader. When the macro
// INSTR_ARB_STARVE_GUARD_EN is defined, a starvation counter is compiled in.
// After the loader has waited MAX_WAIT cycles, it wins one grant over fetch.
//
// Parameters
//   ADDR_WIDTH  byte address width (matches the RAM wrapper)
//   DATA_WIDTH  data width; byte enables are DATA_WIDTH/8
//   MAX_WAIT    loader starvation limit in cycles (>=1, guard build only)
//
// Ports
//   clk, rstn_i                 clock, asynchronous active-low reset
//   fetch_req_i/addr_i          fetch request
//   fetch_gnt_o                 fetch accepted this cycle
//   fetch_rvalid_o/rdata_o      fetch response
//   dbg_req_i/we_i/be_i/addr_i/wdata_i  loader request
//   dbg_gnt_o                   loader accepted this cycle
//   dbg_rvalid_o/rdata_o        loader response (read data or write ack)
//   ram_en_o/we_o/addr_o/wdata_o/be_o   RAM port, driven by the winner
//   ram_rdata_i                 RAM read data, one cycle after ram_en_o
//   dbg_starved_o               guard forcing loader priority (0 if no guard)
module instr_ram_arbiter #(
  parameter int unsigned ADDR_WIDTH = 15,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_WAIT   = 8
) (
  input  logic                    clk,
  input  logic                    rstn_i,
  input  logic                    fetch_req_i,
  input  logic [ADDR_WIDTH-1:0]   fetch_addr_i,
  output logic                    fetch_gnt_o,
  output logic                    fetch_rvalid_o,
  output logic [DATA_WIDTH-1:0]   fetch_rdata_o,
  input  logic                    dbg_req_i,
  input  logic                    dbg_we_i,
  input  logic [DATA_WIDTH/8-1:0] dbg_be_i,
  input  logic [ADDR_WIDTH-1:0]   dbg_addr_i,
  input  logic [DATA_WIDTH-1:0]   dbg_wdata_i,
  output logic                    dbg_gnt_o,
  output logic                    dbg_rvalid_o,
  output logic [DATA_WIDTH-1:0]   dbg_rdata_o,
  output logic                    ram_en_o,
  output logic                    ram_we_o,
  output logic [ADDR_WIDTH-1:0]   ram_addr_o,
  output logic [DATA_WIDTH-1:0]   ram_wdata_o,
  output logic [DATA_WIDTH/8-1:0] ram_be_o,
  input  logic [DATA_WIDTH-1:0]   ram_rdata_i,
  output logic                    dbg_starved_o
);

  typedef enum logic [1:0] {
    OWN_IDLE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_DBG   = 2'd2
  } owner_e;

  owner_e owner_q, owner_d;
  logic   starve_win;

`ifdef INSTR_ARB_STARVE_GUARD_EN
  localparam int unsigned     CW         = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0]   WAIT_LIMIT = CW'(MAX_WAIT);

  logic [CW-1:0] wait_q;

  // Counts cycles the loader has been held off; saturates at the limit and
  // clears once the loader is served or withdraws.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      wait_q <= '0;
    end else if (!dbg_req_i || dbg_gnt_o) begin
      wait_q <= '0;
    end else if (wait_q != WAIT_LIMIT) begin
      wait_q <= wait_q + CW'(1);
    end
  end

  assign dbg_starved_o = (wait_q == WAIT_LIMIT);
  // Only override fetch while the loader is actually asking.
  assign starve_win    = dbg_starved_o && dbg_req_i;
`else
  assign dbg_starved_o = 1'b0;
  assign starve_win    = 1'b0;

  // MAX_WAIT has no effect without the guard; an illegal value is left to
  // surface here as an empty, clearly named block.
  if (MAX_WAIT == 0) begin : g_max_wait_invalid
  end
`endif

  // Grant and RAM port steering
  always_comb begin
    fetch_gnt_o = fetch_req_i && !starve_win;
    dbg_gnt_o   = dbg_req_i && !fetch_gnt_o;

    ram_en_o    = fetch_gnt_o || dbg_gnt_o;
    ram_we_o    = dbg_gnt_o && dbg_we_i;
    ram_wdata_o = dbg_wdata_i;
    ram_addr_o  = dbg_addr_i;
    ram_be_o    = dbg_be_i;
    if (fetch_gnt_o) begin
      ram_addr_o = fetch_addr_i;
      ram_be_o   = '1;
    end
  end

  // Response owner: records who was granted, so that the RAM output one cycle
  // later can be attributed to that requester.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      owner_q <= OWN_IDLE;
    end else begin
      owner_q <= owner_d;
    end
  end

  always_comb begin
    owner_d = OWN_IDLE;
    if (fetch_gnt_o) begin
      owner_d = OWN_FETCH;
    end else if (dbg_gnt_o) begin
      owner_d = OWN_DBG;
    end
    fetch_rvalid_o = (owner_q == OWN_FETCH);
    dbg_rvalid_o   = (owner_q == OWN_DBG);
  end

  assign fetch_rdata_o = ram_rdata_i;
  assign dbg_rdata_o   = ram_rdata_i;

endmodule

// File: tb/tb_instr_ram_arbiter.sv
module tb_instr_ram_arbiter;
  localparam int unsigned AW = 15;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = DW / 8;
  localparam int unsigned MW = 8;
`ifdef INSTR_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstn_i;
  logic          fetch_req_i;
  logic [AW-1:0] fetch_addr_i;
  logic          fetch_gnt_o, fetch_rvalid_o;
  logic [DW-1:0] fetch_rdata_o;
  logic          dbg_req_i, dbg_we_i;
  logic [BW-1:0] dbg_be_i;
  logic [AW-1:0] dbg_addr_i;
  logic [DW-1:0] dbg_wdata_i;
  logic          dbg_gnt_o, dbg_rvalid_o;
  logic [DW-1:0] dbg_rdata_o;
  logic          ram_en_o, ram_we_o;
  logic [AW-1:0] ram_addr_o;
  logic [DW-1:0] ram_wdata_o;
  logic [BW-1:0] ram_be_o;
  logic [DW-1:0] ram_rdata_i;
  logic          dbg_starved_o;

  always #5 clk = ~clk;

  instr_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rstn_i(rstn_i),
    .fetch_req_i(fetch_req_i), .fetch_addr_i(fetch_addr_i), .fetch_gnt_o(fetch_gnt_o),
    .fetch_rvalid_o(fetch_rvalid_o), .fetch_rdata_o(fetch_rdata_o),
    .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i), .dbg_be_i(dbg_be_i),
    .dbg_addr_i(dbg_addr_i), .dbg_wdata_i(dbg_wdata_i), .dbg_gnt_o(dbg_gnt_o),
    .dbg_rvalid_o(dbg_rvalid_o), .dbg_rdata_o(dbg_rdata_o),
    .ram_en_o(ram_en_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_wdata_o(ram_wdata_o), .ram_be_o(ram_be_o), .ram_rdata_i(ram_rdata_i),
    .dbg_starved_o(dbg_starved_o)
  );

  // Behavioural single-port RAM (64 words, read returns old contents)
  logic [DW-1:0] ram_mem [64];
  always @(posedge clk) begin
    if (ram_en_o) begin
      ram_rdata_i <= ram_mem[ram_addr_o[7:2]];
      if (ram_we_o)
        for (int b = 0; b < BW; b++)
          if (ram_be_o[b]) ram_mem[ram_addr_o[7:2]][b*8 +: 8] = ram_wdata_o[b*8 +: 8];
    end
  end

  // Reference model state
  logic [DW-1:0] gold [64];
  int            resp_owner;   // 0 none, 1 fetch, 2 loader
  logic [DW-1:0] resp_data;
  bit            resp_chk;
  int            wait_cnt;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: check last cycle's response, drive a request set,
  // check grants and RAM port against the arbitration rules, advance model.
  task automatic cycle(input logic freq, input logic [AW-1:0] faddr,
                       input logic dreq, input logic dwe, input logic [BW-1:0] dbe,
                       input logic [AW-1:0] daddr, input logic [DW-1:0] dwd,
                       output logic fg, output logic dg);
    bit starved, efg, edg;
    @(negedge clk);
    check_eq("fetch_rvalid", fetch_rvalid_o, resp_owner == 1);
    check_eq("dbg_rvalid", dbg_rvalid_o, resp_owner == 2);
    if (resp_owner == 1) check_eq("fetch_rdata", fetch_rdata_o, resp_data);
    if (resp_owner == 2 && resp_chk) check_eq("dbg_rdata", dbg_rdata_o, resp_data);

    fetch_req_i = freq; fetch_addr_i = faddr;
    dbg_req_i = dreq; dbg_we_i = dwe; dbg_be_i = dbe; dbg_addr_i = daddr; dbg_wdata_i = dwd;
    #1;
    starved = GUARD && (wait_cnt == int'(MW));
    efg = freq && !(starved && dreq);
    edg = dreq && !efg;
    check_eq("fetch_gnt", fetch_gnt_o, efg);
    check_eq("dbg_gnt", dbg_gnt_o, edg);
    check_eq("dbg_starved", dbg_starved_o, starved);
    check_eq("ram_en", ram_en_o, efg || edg);
    check_eq("ram_we", ram_we_o, edg && dwe);
    if (efg) begin
      check_eq("ram_addr_f", ram_addr_o, faddr);
      check_eq("ram_be_f", ram_be_o, {BW{1'b1}});
    end else begin
      check_eq("ram_addr_d", ram_addr_o, daddr);
      check_eq("ram_be_d", ram_be_o, dbe);
      check_eq("ram_wdata", ram_wdata_o, dwd);
    end

    resp_owner = efg ? 1 : (edg ? 2 : 0);
    resp_data  = efg ? gold[faddr[7:2]] : gold[daddr[7:2]];
    resp_chk   = efg || (edg && !dwe);
    if (edg && dwe)
      for (int b = 0; b < BW; b++)
        if (dbe[b]) gold[daddr[7:2]][b*8 +: 8] = dwd[b*8 +: 8];
    if (dreq && !edg) wait_cnt = (wait_cnt < int'(MW)) ? wait_cnt + 1 : wait_cnt;
    else wait_cnt = 0;
    fg = efg; dg = edg;
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    logic [AW-1:0] a;
    a = '0;
    a[7:2] = 6'($urandom_range(0, 63));
    return a;
  endfunction

  logic          fg, dg;
  logic          pf, pd, pdwe;
  logic [AW-1:0] pfa, pda;
  logic [BW-1:0] pdbe;
  logic [DW-1:0] pdwd;

  task automatic random_phase(input int n, input int fetch_pct, input int dbg_pct);
    for (int i = 0; i < n; i++) begin
      if (!pf && ($urandom_range(0, 99) < fetch_pct)) begin
        pf = 1'b1; pfa = rnd_addr();
      end
      if (!pd && ($urandom_range(0, 99) < dbg_pct)) begin
        pd = 1'b1; pdwe = 1'($urandom); pdbe = BW'($urandom); pda = rnd_addr(); pdwd = $urandom;
      end
      cycle(pf, pfa, pd, pdwe, pdbe, pda, pdwd, fg, dg);
      if (fg) pf = 1'b0;
      if (dg) pd = 1'b0;
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      ram_mem[i] = $urandom;
      gold[i] = ram_mem[i];
    end
    resp_owner = 0; resp_data = '0; resp_chk = 1'b0; wait_cnt = 0;
    pf = 1'b0; pd = 1'b0; pdwe = 1'b0; pfa = '0; pda = '0; pdbe = '0; pdwd = '0;
    rstn_i = 1'b0;
    fetch_req_i = 1'b0; fetch_addr_i = '0;
    dbg_req_i = 1'b0; dbg_we_i = 1'b0; dbg_be_i = '0; dbg_addr_i = '0; dbg_wdata_i = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_fetch_rvalid", fetch_rvalid_o, 1'b0);
    check_eq("rst_dbg_rvalid", dbg_rvalid_o, 1'b0);
    check_eq("rst_starved", dbg_starved_o, 1'b0);
    rstn_i = 1'b1;

    // Fetch back to back
    cycle(1'b1, 15'h0010, 1'b0, 1'b0, '0, '0, '0, fg, dg);
    cycle(1'b1, 15'h0014, 1'b0, 1'b0, '0, '0, '0, fg, dg);
    cycle(1'b0, '0, 1'b0, 1'b0, '0, '0, '0, fg, dg);

    // Partial write then read back
    cycle(1'b0, '0, 1'b1, 1'b1, 4'b0011, 15'h0040, 32'hDEADBEEF, fg, dg);
    cycle(1'b0, '0, 1'b1, 1'b0, 4'b1111, 15'h0040, '0, fg, dg);
    cycle(1'b0, '0, 1'b0, 1'b0, '0, '0, '0, fg, dg);
    check_eq("wr_rd_low_half", dbg_rdata_o[15:0], 16'hBEEF);

    // Simultaneous requests, then loader once fetch drops
    cycle(1'b1, 15'h0020, 1'b1, 1'b0, 4'hF, 15'h0030, '0, fg, dg);
    cycle(1'b0, '0, 1'b1, 1'b0, 4'hF, 15'h0030, '0, fg, dg);
    cycle(1'b0, '0, 1'b0, 1'b0, '0, '0, '0, fg, dg);

    // Fetch hogging with the loader pending from T0
    for (int t = 0; t < 11; t++) begin
      cycle(1'b1, rnd_addr(), ~dg | (t == 0), 1'b0, 4'hF, 15'h0044, '0, fg, dg);
      if (t == 8) check_eq("starve_t8_dbg_gnt", dg, GUARD);
    end
    cycle(1'b0, '0, 1'b0, 1'b0, '0, '0, '0, fg, dg);

    // Reset in the cycle after a loader read grant
    cycle(1'b0, '0, 1'b1, 1'b0, 4'hF, 15'h0048, '0, fg, dg);
    @(negedge clk);
    check_eq("pre_reset_dbg_rvalid", dbg_rvalid_o, 1'b1);
    rstn_i = 1'b0; fetch_req_i = 1'b1; fetch_addr_i = 15'h0008; dbg_req_i = 1'b0;
    #1;
    check_eq("reset_dbg_rvalid", dbg_rvalid_o, 1'b0);
    check_eq("reset_comb_fetch_gnt", fetch_gnt_o, 1'b1);
    check_eq("reset_comb_ram_en", ram_en_o, 1'b1);
    @(negedge clk);
    check_eq("reset_hold_fetch_rvalid", fetch_rvalid_o, 1'b0);
    rstn_i = 1'b1; fetch_req_i = 1'b0;
    resp_owner = 0; wait_cnt = 0;
    cycle(1'b0, '0, 1'b1, 1'b0, 4'hF, 15'h0048, '0, fg, dg);
    cycle(1'b0, '0, 1'b0, 1'b0, '0, '0, '0, fg, dg);

    // Randomized traffic: balanced, then fetch-heavy to provoke starvation
    random_phase(600, 60, 50);
    random_phase(400, 97, 40);
    pf = 1'b0; pd = 1'b0;
    cycle(1'b0, '0, 1'b0, 1'b0, '0, '0, '0, fg, dg);
    cycle(1'b0, '0, 1'b0, 1'b0, '0, '0, '0, fg, dg);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
